// File: rtl/spike_rate_encoder_pkg.sv
// Shared types and constants for the spike rate encoder.
// Also used by the LFSR that other blocks reuse for weight noise.
package spike_rate_encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_DET   = 1'b0;
    localparam logic MODE_STOCH = 1'b1;

    // Fibonacci taps 16,14,13,11 expressed on a right-shifting register.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/spike_lfsr16.sv
// 16-bit Fibonacci LFSR with step and seed-load controls.
// A zero seed locks the register at zero; callers must avoid it.
module spike_lfsr16
    import spike_rate_encoder_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    input  logic        step_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic        fb;

    assign fb      = ^(state_q & LFSR_TAPS);
    assign state_o = state_q;

    // Seed on reset or load, otherwise shift right feeding the parity in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= seed_i;
        end else if (step_i) begin
            state_q <= {fb, state_q[15:1]};
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Turns per-channel intensities into spike trains, one vector per tick.
// Deterministic mode uses phase accumulators, stochastic mode an LFSR.
module spike_rate_encoder
    import spike_rate_encoder_pkg::*;
#(
    parameter int          CHANNELS  = 8,
    parameter int          VAL_W     = 8,
    parameter int          WINDOW    = 16,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VAL_W-1:0]    in_data,
    input  logic                in_last,
    input  logic                start,
    input  logic                mode,
    input  logic                tick_en,
    output logic [CHANNELS-1:0] spikes_out,
    output logic                spikes_valid,
    output logic                frame_done,
    output logic                busy
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TCK_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHANNELS - 1);
    localparam logic [TCK_W-1:0] TICK_LAST = TCK_W'(WINDOW - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [TCK_W-1:0]      tick_q, tick_d;
    logic                  mode_q, mode_d;
    logic [VAL_W-1:0]      intens_q [CHANNELS];
    logic [VAL_W-1:0]      intens_d [CHANNELS];
    logic [VAL_W-1:0]      acc_q [CHANNELS];
    logic [VAL_W-1:0]      acc_d [CHANNELS];
    logic [CHANNELS-1:0]   spikes_q, spikes_d;
    logic                  svalid_q, svalid_d;
    logic                  fdone_q, fdone_d;
    logic                  lfsr_step;
    logic [15:0]           lfsr;
    logic [VAL_W-1:0]      rnd [CHANNELS];
    logic [VAL_W:0]        sum;

    spike_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load_i (1'b0),
        .seed_i (LFSR_SEED),
        .step_i (lfsr_step),
        .state_o(lfsr)
    );

    assign in_ready     = (state_q == IDLE);
    assign busy         = (state_q == RUN);
    assign spikes_out   = spikes_q;
    assign spikes_valid = svalid_q;
    assign frame_done   = fdone_q;

    // Per-channel random threshold: a wrapping window onto the LFSR.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < VAL_W; b++) begin
                rnd[c][b] = lfsr[(c + b) % 16];
            end
        end
    end

    // Load port, frame start and per-tick spike generation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tick_d    = tick_q;
        mode_d    = mode_q;
        intens_d  = intens_q;
        acc_d     = acc_q;
        spikes_d  = '0;
        svalid_d  = 1'b0;
        fdone_d   = 1'b0;
        lfsr_step = 1'b0;
        sum       = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    intens_d[idx_q] = in_data;
                    if (in_last || idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                if (start) begin
                    state_d = RUN;
                    tick_d  = '0;
                    mode_d  = mode;
                    for (int c = 0; c < CHANNELS; c++) begin
                        acc_d[c] = '0;
                    end
                end
            end
            RUN: begin
                if (tick_en) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (mode_q == MODE_DET) begin
                            sum = {1'b0, acc_q[c]} + {1'b0, intens_q[c]};
                            spikes_d[c] = sum[VAL_W];
                            acc_d[c]    = sum[VAL_W-1:0];
                        end else begin
                            spikes_d[c] = (intens_q[c] > rnd[c]);
                        end
                    end
                    lfsr_step = (mode_q == MODE_STOCH);
                    svalid_d  = 1'b1;
                    if (tick_q == TICK_LAST) begin
                        fdone_d = 1'b1;
                        state_d = IDLE;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            tick_q   <= '0;
            mode_q   <= MODE_DET;
            spikes_q <= '0;
            svalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                intens_q[c] <= '0;
                acc_q[c]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
            spikes_q <= spikes_d;
            svalid_q <= svalid_d;
            fdone_q  <= fdone_d;
            intens_q <= intens_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder.
// Expected spike counts are worked out by hand from the load values.
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       start;
    logic       mode;
    logic       tick_en;
    logic [7:0] spikes_out;
    logic       spikes_valid;
    logic       frame_done;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    int         cnt [8];
    int         pulses;
    int         done_at;
    int         done_n;
    int         bad;
    logic [7:0] cur_seq [16];
    logic [7:0] seq_a [16];
    logic [7:0] seq_b [16];
    logic [7:0] ld [8];
    int         diffs;
    int         sum_c;

    spike_rate_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .start       (start),
        .mode        (mode),
        .tick_en     (tick_en),
        .spikes_out  (spikes_out),
        .spikes_valid(spikes_valid),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++) begin
            beat(ld[i], i == 7);
        end
    endtask

    // Starts a frame, ticks every 'per' cycles and gathers statistics.
    // 'stop_at' > 0 ends the loop early after that many pulses.
    task automatic run_frame(input logic md, input int per,
                             input logic noise, input int stop_at);
        logic prev_te;
        for (int c = 0; c < 8; c++) cnt[c] = 0;
        pulses  = 0;
        done_at = 0;
        done_n  = 0;
        bad     = 0;
        mode    = md;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        if (!busy) bad++;
        for (int k = 0; k < 16 * per + 8; k++) begin
            if (pulses == 16 || (stop_at > 0 && pulses == stop_at)) break;
            prev_te  = ((k % per) == 0);
            tick_en  = prev_te;
            in_valid = noise;
            in_data  = 8'hFF;
            cyc();
            if (noise && in_ready && !frame_done) bad++;
            if (spikes_valid !== prev_te) bad++;
            if (!spikes_valid && spikes_out !== 8'h00) bad++;
            if (frame_done && !spikes_valid) bad++;
            if (spikes_valid) begin
                cur_seq[pulses] = spikes_out;
                pulses++;
                for (int c = 0; c < 8; c++) cnt[c] += spikes_out[c];
            end
            if (frame_done) begin
                done_n++;
                done_at = pulses;
            end
        end
        tick_en  = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int e0, input int e1,
                                input int e2, input int e3, input int e4,
                                input int e5, input int e6, input int e7);
        int e [8];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("%s_ch%0d", tag, c), cnt[c], e[c]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        tick_en  = 1'b0;
        ld = '{8'd0, 8'd16, 8'd64, 8'd128, 8'd192, 8'd255, 8'd1, 8'd32};

        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_spikes", spikes_out, 0);
        chk("rst_svalid", spikes_valid, 0);
        chk("rst_fdone", frame_done, 0);

        // Deterministic, ticking every cycle.
        load_all();
        run_frame(1'b0, 1, 1'b0, 0);
        check_counts("det1", 0, 1, 4, 8, 12, 15, 0, 2);
        chk("det1_pulses", pulses, 16);
        chk("det1_done_at", done_at, 16);
        chk("det1_done_n", done_n, 1);
        chk("det1_protocol", bad, 0);
        tick_en = 1'b1;
        cyc();
        chk("det1_busy_after", busy, 0);
        chk("det1_ready_after", in_ready, 1);
        cyc();
        chk("det1_no_extra", spikes_valid, 0);
        tick_en = 1'b0;

        // Replay without reload, ticking every third cycle.
        run_frame(1'b0, 3, 1'b0, 0);
        check_counts("det3", 0, 1, 4, 8, 12, 15, 0, 2);
        chk("det3_pulses", pulses, 16);
        chk("det3_protocol", bad, 0);

        // Stochastic run and its repeat from a fresh reset.
        do_reset();
        load_all();
        run_frame(1'b1, 1, 1'b0, 0);
        seq_a = cur_seq;
        chk("sto_ch0_zero", cnt[0], 0);
        chk("sto_ch5_high", int'(cnt[5] >= 14), 1);
        chk("sto_pulses", pulses, 16);
        chk("sto_protocol", bad, 0);
        do_reset();
        load_all();
        run_frame(1'b1, 1, 1'b0, 0);
        seq_b = cur_seq;
        diffs = 0;
        for (int i = 0; i < 16; i++) begin
            if (seq_a[i] !== seq_b[i]) diffs++;
        end
        chk("sto_repeat_diffs", diffs, 0);

        // Early in_last wraps the index; RUN ignores in_valid.
        do_reset();
        beat(8'h40, 1'b0);
        beat(8'h80, 1'b0);
        beat(8'hC0, 1'b1);
        beat(8'hF0, 1'b0);
        run_frame(1'b0, 1, 1'b1, 0);
        check_counts("wrap", 15, 8, 12, 0, 0, 0, 0, 0);
        chk("wrap_protocol", bad, 0);
        run_frame(1'b0, 2, 1'b0, 0);
        check_counts("wrap_keep", 15, 8, 12, 0, 0, 0, 0, 0);

        // Reset in the middle of a frame.
        do_reset();
        load_all();
        run_frame(1'b0, 1, 1'b0, 5);
        chk("abort_pulses", pulses, 5);
        reset   = 1'b1;
        tick_en = 1'b1;
        cyc();
        chk("abort_fdone", frame_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_spikes", spikes_out, 0);
        chk("abort_svalid", spikes_valid, 0);
        reset   = 1'b0;
        tick_en = 1'b0;
        cyc();
        for (int m = 0; m < 2; m++) begin
            run_frame(m[0], 1, 1'b0, 0);
            sum_c = 0;
            for (int c = 0; c < 8; c++) sum_c += cnt[c];
            chk($sformatf("abort_zero_m%0d", m), sum_c, 0);
            chk($sformatf("abort_pulses_m%0d", m), pulses, 16);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts per-channel 8-bit intensities into binary spike trains that drive the neuron's x input vector, one spike vector per tick.
- Sits upstream of the LIF neuron top as the transmit side of its spike-input interface.
- Intensities are loaded byte-serially over a valid/ready port.
- A frame of WINDOW ticks then runs in deterministic (phase-accumulator) or stochastic (LFSR) mode.

Parameters:
- CHANNELS, 8, number of spike channels (width of spikes_out).
- VAL_W, 8, intensity / accumulator width.
- WINDOW, 16, ticks per frame.
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  intensity beat valid
- in_ready  out  1  encoder accepts a beat (high only in IDLE)
- in_data  in  VAL_W  intensity for the current load index
- in_last  in  1  final beat of a load burst
- start  in  1  begin a frame (honoured in IDLE only)
- mode  in  1  0 = deterministic accumulator, 1 = stochastic LFSR; sampled at start
- tick_en  in  1  advance one tick (honoured in RUN only)
- spikes_out  out  CHANNELS  spike vector; zero whenever spikes_valid=0
- spikes_valid  out  1  one-cycle pulse per tick
- frame_done  out  1  pulse coincident with the WINDOW-th spikes_valid
- busy  out  1  high in RUN

Behaviour:
- Reset: synchronous, active-high; the clock is clk. On reset:
  - state=IDLE; intensities, accumulators, load index and tick counter cleared to 0.
  - LFSR=LFSR_SEED; mode register=0.
  - Outputs: in_ready=1, spikes_out=0, spikes_valid=0, frame_done=0, busy=0.
- FSM has two states, IDLE and RUN.
- IDLE:
  - in_ready=1. A beat is accepted when in_valid=1: intensity[idx] <= in_data.
  - idx increments; it returns to 0 after idx=CHANNELS-1 or on any beat with in_last=1.
  - An early in_last leaves higher channels holding their previous values.
- start in IDLE:
  - Next state RUN; tick counter and all accumulators are cleared; mode is latched.
  - A beat accepted in the same cycle as start is written, and it is visible to the first tick.
- RUN:
  - in_ready=0; in_valid is ignored with no write and no idx change.
  - start is ignored.
  - Cycles with tick_en=0 hold all state.
- Tick (tick_en=1 in RUN cycle n): spikes_out and spikes_valid are registered and appear at cycle n+1.
  - Deterministic mode: sum = acc[c] + intensity[c], computed VAL_W+1 bits wide. spike[c] = sum[VAL_W] (carry). acc[c] <= sum[VAL_W-1:0].
  - Resulting count per frame = floor(intensity*WINDOW/2^VAL_W).
  - Stochastic mode: rnd_c = VAL_W-bit slice of the LFSR starting at bit (c mod 16), wrapping modulo 16. spike[c] = (intensity[c] > rnd_c), a strict compare, so intensity 0 never spikes.
  - The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11, stepped once per tick after the compare. It is not reseeded per frame; only reset restores the seed.
- Tick counter counts 0..WINDOW-1. On the tick where count=WINDOW-1:
  - frame_done pulses with that tick's spikes_valid (cycle n+1);
  - state returns to IDLE at n+1, and in_ready=1 at n+1.
- Reset mid-RUN: immediate abort to the reset values above; no frame_done is issued.
- Intensities persist across frames; re-running start without a new load replays the same values.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN};
  - mode constants MODE_DET=0, MODE_STOCH=1;
  - LFSR tap mask;
  - default LFSR_SEED.
- One sub-module is natural: spike_lfsr16, a 16-bit LFSR with step and seed-load inputs, reusable for weight noise elsewhere.

Test Plan:
- Reset -> in_ready=1, busy=0, spikes_out=0, spikes_valid=0, frame_done=0 on the cycle after reset.
- Load [0,16,64,128,192,255,1,32] (last on beat 8), start with mode=0, tick_en held high 16 cycles -> per-channel spike counts 0,1,4,8,12,15,0,2. Also: exactly 16 spikes_valid pulses, frame_done on the 16th, busy low the following cycle.
- Same load with tick_en asserted every third cycle -> identical counts; each spikes_valid appears exactly one cycle after its tick_en; spikes_out=0 in all other cycles.
- mode=1 with intensity 0 on channel 0 and 255 on channel 5 -> channel 0 count 0, channel 5 count >=14. A repeat run after a fresh reset gives a bit-identical spike sequence.
- Load 3 beats with in_last on beat 3, then one more beat -> that beat writes channel 0. in_valid during RUN -> in_ready=0 and intensities unchanged.
- Assert reset at tick 5 of a frame -> no frame_done, busy=0, spikes_out=0. A subsequent start without a load gives 0 spikes over the full frame in both modes.
